// File: rtl/jtag_user_dr.sv
// User data-register bridge for the ECP5 JTAGG ER1/ER2 channels: capture, LSB-first shift, length-checked commit.
// Optional JTAG_DR_LOOPBACK_EN: Capture reloads the last committed word instead of the capture port.
module jtag_user_dr_chan #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         shift,
    input  logic         tdi,
    input  logic         upd_en,
    input  logic         err_clr,
    input  logic [W-1:0] cap,
    output logic         tdo,
    output logic [W-1:0] upd,
    output logic         stb,
    output logic         err
);
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_OVER = CW'(W + 1);

    logic [W-1:0]  sh_q;
    logic [W-1:0]  sh_d;
    logic [W-1:0]  upd_q;
    logic [W-1:0]  cap_src;
    logic [CW-1:0] cnt_q;
    logic          stb_q;
    logic          err_q;

    generate
        if (W == 1) begin : g_narrow
            assign sh_d = tdi;
        end else begin : g_wide
            assign sh_d = {tdi, sh_q[W-1:1]};
        end
    endgenerate

`ifdef JTAG_DR_LOOPBACK_EN
    assign cap_src = upd_q;
`else
    assign cap_src = cap;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            upd_q <= RST_VAL;
            cnt_q <= '0;
            stb_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (ce) begin
                if (shift) begin
                    sh_q <= sh_d;
                    // Counter parks at W+1 so an overlong scan can never alias to W.
                    if (cnt_q != CNT_OVER) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    sh_q  <= cap_src;
                    cnt_q <= '0;
                end
            end else if (upd_en) begin
                cnt_q <= '0;
                if (cnt_q == CNT_FULL) begin
                    upd_q <= sh_q;
                    stb_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign tdo = sh_q[0];
    assign upd = upd_q;
    assign stb = stb_q;
    assign err = err_q;
endmodule

module jtag_user_dr #(
    parameter int               DR1_W    = 8,
    parameter int               DR2_W    = 8,
    parameter logic [DR1_W-1:0] RST_VAL1 = '0,
    parameter logic [DR2_W-1:0] RST_VAL2 = '0
) (
    input  logic             jtck,
    input  logic             jrst,
    input  logic             jtdi,
    input  logic             jshift,
    input  logic             jupdate,
    input  logic             jce1,
    input  logic             jce2,
    input  logic             jrti1,
    input  logic             jrti2,
    output logic             jtdo1,
    output logic             jtdo2,
    input  logic [DR1_W-1:0] cap1,
    input  logic [DR2_W-1:0] cap2,
    output logic [DR1_W-1:0] upd1,
    output logic [DR2_W-1:0] upd2,
    output logic [1:0]       upd_stb,
    output logic [1:0]       rti_stb,
    output logic [1:0]       len_err,
    input  logic             err_clr
);
    typedef enum logic [1:0] {SEL_NONE, SEL_CH1, SEL_CH2} sel_e;

    sel_e       sel_q;
    logic [1:0] rti_prev_q;
    logic [1:0] rti_stb_q;
    logic       stb1;
    logic       stb2;
    logic       err1;
    logic       err2;

    always_ff @(posedge jtck or posedge jrst) begin
        if (jrst) begin
            sel_q      <= SEL_NONE;
            rti_prev_q <= 2'b00;
            rti_stb_q  <= 2'b00;
        end else begin
            if (jce1) begin
                sel_q <= SEL_CH1;
            end else if (jce2) begin
                sel_q <= SEL_CH2;
            end
            rti_prev_q <= {jrti2, jrti1};
            rti_stb_q  <= {jrti2, jrti1} & ~rti_prev_q;
        end
    end

    // ER1 has priority: channel 2 sits out any cycle where both enables are high.
    jtag_user_dr_chan #(.W(DR1_W), .RST_VAL(RST_VAL1)) u_ch1 (
        .clk(jtck), .rst(jrst), .ce(jce1), .shift(jshift), .tdi(jtdi),
        .upd_en(jupdate && (sel_q == SEL_CH1)), .err_clr(err_clr), .cap(cap1),
        .tdo(jtdo1), .upd(upd1), .stb(stb1), .err(err1)
    );

    jtag_user_dr_chan #(.W(DR2_W), .RST_VAL(RST_VAL2)) u_ch2 (
        .clk(jtck), .rst(jrst), .ce(jce2 && !jce1), .shift(jshift), .tdi(jtdi),
        .upd_en(jupdate && (sel_q == SEL_CH2)), .err_clr(err_clr), .cap(cap2),
        .tdo(jtdo2), .upd(upd2), .stb(stb2), .err(err2)
    );

    assign upd_stb = {stb2, stb1};
    assign len_err = {err2, err1};
    assign rti_stb = rti_stb_q;
endmodule

// File: tb/tb_jtag_user_dr.sv
// Randomized scoreboard bench for jtag_user_dr: bit-queue reference model, commit monitor, directed corner scans.
module tb_jtag_user_dr;
    localparam logic [7:0] RV1 = 8'h81;
    localparam logic [7:0] RV2 = 8'h42;

    logic jtck = 1'b0;
    logic jrst = 1'b1;
    logic jtdi = 1'b0, jshift = 1'b0, jupdate = 1'b0;
    logic jce1 = 1'b0, jce2 = 1'b0, jrti1 = 1'b0, jrti2 = 1'b0;
    logic err_clr = 1'b0;
    logic [7:0] cap1 = '0, cap2 = '0;
    logic jtdo1, jtdo2;
    logic [7:0] upd1, upd2;
    logic [1:0] upd_stb, rti_stb, len_err;

    jtag_user_dr #(.DR1_W(8), .DR2_W(8), .RST_VAL1(RV1), .RST_VAL2(RV2)) dut (
        .jtck(jtck), .jrst(jrst), .jtdi(jtdi), .jshift(jshift), .jupdate(jupdate),
        .jce1(jce1), .jce2(jce2), .jrti1(jrti1), .jrti2(jrti2),
        .jtdo1(jtdo1), .jtdo2(jtdo2), .cap1(cap1), .cap2(cap2),
        .upd1(upd1), .upd2(upd2), .upd_stb(upd_stb), .rti_stb(rti_stb),
        .len_err(len_err), .err_clr(err_clr)
    );

    always #5 jtck = ~jtck;

    typedef struct packed {
        logic [1:0] mask;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_upd[2];
    logic [1:0] m_err;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Commit monitor: every strobe must match the oldest expected commit.
    always @(negedge jtck) begin
        if (!jrst && upd_stb !== 2'b00) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_stb got=%b at %0t", upd_stb, $time);
            end else begin
                e = exp_q.pop_front();
                if (upd_stb !== e.mask || (e.mask[0] ? upd1 : upd2) !== e.val) begin
                    errors++;
                    $display("FAIL commit got stb=%b val=%h expected stb=%b val=%h",
                             upd_stb, e.mask[0] ? upd1 : upd2, e.mask, e.val);
                end else begin
                    $display("commit ch%0d val=%h ok", e.mask[0] ? 1 : 2, e.val);
                end
            end
        end
    end

    task automatic check_state(input string name);
        check({name, "_upd1"}, {8'h0, upd1}, {8'h0, m_upd[0]});
        check({name, "_upd2"}, {8'h0, upd2}, {8'h0, m_upd[1]});
        check({name, "_len_err"}, {14'h0, len_err}, {14'h0, m_err});
    endtask

    task automatic scan(input int ch, input logic [7:0] c, input int len,
                        input logic [15:0] d, input bit clr);
        bit         q[$];
        logic [7:0] src;
        logic [7:0] v;
        @(negedge jtck);
`ifdef JTAG_DR_LOOPBACK_EN
        src = m_upd[ch];
`else
        src = c;
`endif
        if (ch == 0) begin cap1 = c; jce1 = 1'b1; end
        else         begin cap2 = c; jce2 = 1'b1; end
        jshift = 1'b0;
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(src[i]);
        for (int k = 0; k < len; k++) begin
            @(negedge jtck);
            check("tdo", {15'h0, (ch == 0) ? jtdo1 : jtdo2}, {15'h0, q[0]});
            void'(q.pop_front());
            q.push_back(d[k]);
            jshift = 1'b1;
            jtdi   = d[k];
        end
        @(negedge jtck);
        jce1 = 1'b0; jce2 = 1'b0; jshift = 1'b0;
        jupdate = 1'b1;
        err_clr = clr;
        if (clr) m_err = 2'b00;
        if (len == 8) begin
            for (int i = 0; i < 8; i++) v[i] = q[i];
            exp_q.push_back('{mask: (ch == 0) ? 2'b01 : 2'b10, val: v});
            m_upd[ch] = v;
        end else begin
            m_err[ch] = 1'b1;
        end
        @(negedge jtck);
        jupdate = 1'b0;
        err_clr = 1'b0;
        $display("scan ch%0d len=%0d data=%h clr=%0d", ch + 1, len, d, clr);
        check_state("scan");
    endtask

    task automatic rti_pulse(input int ch);
        @(negedge jtck);
        if (ch == 0) jrti1 = 1'b1; else jrti2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge jtck);
            check("rti_stb", {14'h0, rti_stb}, (i == 0) ? ((ch == 0) ? 16'd1 : 16'd2) : 16'd0);
        end
        jrti1 = 1'b0; jrti2 = 1'b0;
        @(negedge jtck);
        check("rti_fall", {14'h0, rti_stb}, 16'd0);
        $display("rti ch%0d pulse checked", ch + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int len, ch;
        m_upd[0] = RV1; m_upd[1] = RV2; m_err = 2'b00;
        #12;
        check("rst_tdo", {14'h0, jtdo2, jtdo1}, 16'd0);
        check("rst_stb", {14'h0, upd_stb}, 16'd0);
        check("rst_rti", {14'h0, rti_stb}, 16'd0);
        check_state("rst");
        @(negedge jtck);
        jrst = 1'b0;

        // Update-DR with no channel selected since reset must be ignored.
        @(negedge jtck); jupdate = 1'b1;
        @(negedge jtck); jupdate = 1'b0;
        check_state("sel_none");

        scan(0, 8'hFF, 8, 16'h00A5, 1'b0);
        scan(1, 8'h00, 8, 16'h003C, 1'b0);
        scan(0, 8'h5A, 5, 16'h0013, 1'b0);
        @(negedge jtck); err_clr = 1'b1;
        @(negedge jtck); err_clr = 1'b0; m_err = 2'b00;
        check_state("err_clr");
        scan(1, 8'hC3, 0, 16'h0000, 1'b0);
        scan(1, 8'h99, 11, 16'h0ABC, 1'b1);
        scan(0, 8'h00, 8, 16'h005A, 1'b0);
        scan(0, 8'h11, 8, 16'h00E7, 1'b0);

        rti_pulse(1);
        rti_pulse(0);

        for (int n = 0; n < 40; n++) begin
            ch = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       len = $urandom_range(0, 7);
                1:       len = $urandom_range(9, 12);
                default: len = 8;
            endcase
            scan(ch, 8'($urandom), len, 16'($urandom), $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a shift discards it and restores the reset words.
        @(negedge jtck); cap1 = 8'h77; jce1 = 1'b1;
        repeat (3) begin @(negedge jtck); jshift = 1'b1; jtdi = 1'b1; end
        @(negedge jtck); jrst = 1'b1; jce1 = 1'b0; jshift = 1'b0;
        m_upd[0] = RV1; m_upd[1] = RV2; m_err = 2'b00;
        #1;
        check("midrst_tdo", {14'h0, jtdo2, jtdo1}, 16'd0);
        check_state("midrst");
        @(negedge jtck); jrst = 1'b0;
        scan(0, 8'h3E, 8, 16'h00C9, 1'b0);

        repeat (3) @(negedge jtck);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
